shifter_operand_fetch: RTL and testbench

- Operand-fetch stage directly upstream of barrel_shifter for data-processing instructions.
- Accepts a decoded instruction and PC from decode over a valid/ready handshake, and reads Rn, Rm and Rs from the two-port register file.
- Presents a registered bundle to execute: barrel_sel, shiftee, shifter, Rn value and the instruction.
- Register-specified shifts need three reads, so they take one extra cycle.

---
 rtl/shifter_operand_fetch_pkg.sv | 34 +++
 rtl/shifter_operand_fetch_decode.sv | 39 +++
 rtl/shifter_operand_fetch.sv | 127 ++++++++++++
 tb/tb_shifter_operand_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_operand_fetch_pkg.sv
// Shared definitions for the data-processing operand path: barrel_sel
// encodings, instruction field positions, the PC register index and FSM states.
package shifter_operand_fetch_pkg;

  localparam logic [3:0] BSEL_IMMED  = 4'b1000;
  localparam logic [3:0] BSEL_LSLIMM = 4'b0000;
  localparam logic [3:0] BSEL_LSLREG = 4'b0001;
  localparam logic [3:0] BSEL_LSRIMM = 4'b0010;
  localparam logic [3:0] BSEL_LSRREG = 4'b0011;
  localparam logic [3:0] BSEL_ASRIMM = 4'b0100;
  localparam logic [3:0] BSEL_ASRREG = 4'b0101;
  localparam logic [3:0] BSEL_RORIMM = 4'b0110;
  localparam logic [3:0] BSEL_RORREG = 4'b0111;

  localparam int unsigned F_I_BIT        = 25;
  localparam int unsigned F_REGSHIFT_BIT = 4;
  localparam int unsigned F_SHTYPE_LSB   = 5;
  localparam int unsigned F_SHAMT_LSB    = 7;
  localparam int unsigned F_RN_LSB       = 16;
  localparam int unsigned F_RS_LSB       = 8;
  localparam int unsigned F_RM_LSB       = 0;

  localparam logic [3:0] REG_PC = 4'd15;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RS_READ = 1'b1;

  typedef enum logic [1:0] {
    FORM_IMM,
    FORM_IMM_SHIFT,
    FORM_REG_SHIFT
  } form_t;

endpackage

// File: rtl/shifter_operand_fetch_decode.sv
// Combinational shifter-operand decode: form, barrel_sel and the immediate
// shiftee/shifter values taken straight from the instruction word.
module shifter_operand_fetch_decode
  import shifter_operand_fetch_pkg::*;
(
  input  logic        i_imm,
  input  logic [11:0] i_op2,
  output form_t       o_form,
  output logic [3:0]  o_barrel_sel,
  output logic [31:0] o_imm_shiftee,
  output logic [31:0] o_imm_shifter
);

  always_comb begin
    o_form = FORM_IMM_SHIFT;
    if (i_imm) begin
      o_form = FORM_IMM;
    end else if (i_op2[F_REGSHIFT_BIT]) begin
      o_form = FORM_REG_SHIFT;
    end

    o_barrel_sel = BSEL_LSLIMM;
    case (i_op2[F_SHTYPE_LSB +: 2])
      2'b00:   o_barrel_sel = i_op2[F_REGSHIFT_BIT] ? BSEL_LSLREG : BSEL_LSLIMM;
      2'b01:   o_barrel_sel = i_op2[F_REGSHIFT_BIT] ? BSEL_LSRREG : BSEL_LSRIMM;
      2'b10:   o_barrel_sel = i_op2[F_REGSHIFT_BIT] ? BSEL_ASRREG : BSEL_ASRIMM;
      default: o_barrel_sel = i_op2[F_REGSHIFT_BIT] ? BSEL_RORREG : BSEL_RORIMM;
    endcase
    if (i_imm) begin
      o_barrel_sel = BSEL_IMMED;
    end

    // Rotate field is passed undoubled; the barrel shifter applies the x2.
    o_imm_shiftee = {24'b0, i_op2[7:0]};
    o_imm_shifter = i_imm ? {28'b0, i_op2[F_RS_LSB +: 4]}
                          : {27'b0, i_op2[F_SHAMT_LSB +: 5]};
  end

endmodule

// File: rtl/shifter_operand_fetch.sv
// Operand-fetch stage ahead of the barrel shifter: reads Rn/Rm (and Rs for
// register shifts, one cycle later) from a two-port register file.
module shifter_operand_fetch
  import shifter_operand_fetch_pkg::*;
#(
  parameter logic [31:0] PC_OFS_IMM = 32'd8,
  parameter logic [31:0] PC_OFS_REG = 32'd12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [3:0]  rf_addr_a,
  input  logic [31:0] rf_data_a,
  output logic [3:0]  rf_addr_b,
  input  logic [31:0] rf_data_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_barrel_sel,
  output logic [31:0] out_shiftee,
  output logic [31:0] out_shifter,
  output logic [31:0] out_rn,
  output logic [31:0] out_instr
);

  logic [0:0]  r_state;
  logic        r_out_valid;
  logic [3:0]  r_barrel_sel;
  logic [31:0] r_shiftee;
  logic [31:0] r_shifter;
  logic [31:0] r_rn;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  form_t       w_form;
  logic [3:0]  w_barrel_sel;
  logic [31:0] w_imm_shiftee;
  logic [31:0] w_imm_shifter;
  logic        w_idle;
  logic        w_in_ready;
  logic        w_accept;
  logic [3:0]  w_addr_a;
  logic [3:0]  w_addr_b;
  logic [31:0] w_pc_val;
  logic [31:0] w_val_a;
  logic [31:0] w_val_b;

  shifter_operand_fetch_decode u_decode (
    .i_imm         (in_instr[F_I_BIT]),
    .i_op2         (in_instr[11:0]),
    .o_form        (w_form),
    .o_barrel_sel  (w_barrel_sel),
    .o_imm_shiftee (w_imm_shiftee),
    .o_imm_shifter (w_imm_shifter)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign w_in_ready = w_idle && (!r_out_valid || out_ready) && !flush;
  assign w_accept   = in_valid && w_in_ready;

  assign w_addr_a = w_idle ? in_instr[F_RN_LSB +: 4] : r_instr[F_RS_LSB +: 4];
  assign w_addr_b = w_idle ? in_instr[F_RM_LSB +: 4] : r_instr[F_RM_LSB +: 4];

  // RS_READ only ever serves a register-shift form, so it always uses the +12 view.
  assign w_pc_val = w_idle ? (in_pc + ((w_form == FORM_REG_SHIFT) ? PC_OFS_REG : PC_OFS_IMM))
                           : (r_pc + PC_OFS_REG);
  assign w_val_a  = (w_addr_a == REG_PC) ? w_pc_val : rf_data_a;
  assign w_val_b  = (w_addr_b == REG_PC) ? w_pc_val : rf_data_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_out_valid  <= 1'b0;
      r_barrel_sel <= '0;
      r_shiftee    <= '0;
      r_shifter    <= '0;
      r_rn         <= '0;
      r_instr      <= '0;
      r_pc         <= '0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end else if (r_state == ST_RS_READ) begin
      r_shifter   <= w_val_a;
      r_out_valid <= 1'b1;
      r_state     <= ST_IDLE;
    end else if (w_accept) begin
      r_instr      <= in_instr;
      r_pc         <= in_pc;
      r_barrel_sel <= w_barrel_sel;
      r_rn         <= w_val_a;
      case (w_form)
        FORM_IMM: begin
          r_shiftee   <= w_imm_shiftee;
          r_shifter   <= w_imm_shifter;
          r_out_valid <= 1'b1;
        end
        FORM_REG_SHIFT: begin
          r_shiftee   <= w_val_b;
          r_out_valid <= 1'b0;
          r_state     <= ST_RS_READ;
        end
        default: begin
          r_shiftee   <= w_val_b;
          r_shifter   <= w_imm_shifter;
          r_out_valid <= 1'b1;
        end
      endcase
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready       = w_in_ready;
  assign rf_addr_a      = w_addr_a;
  assign rf_addr_b      = w_addr_b;
  assign out_valid      = r_out_valid;
  assign out_barrel_sel = r_barrel_sel;
  assign out_shiftee    = r_shiftee;
  assign out_shifter    = r_shifter;
  assign out_rn         = r_rn;
  assign out_instr      = r_instr;

endmodule

// File: tb/tb_shifter_operand_fetch.sv
// Self-checking bench for shifter_operand_fetch: directed scenarios plus a
// randomized stream checked against an instruction-level reference model.
module tb_shifter_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [3:0]  rf_addr_a;
  logic [31:0] rf_data_a;
  logic [3:0]  rf_addr_b;
  logic [31:0] rf_data_b;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_barrel_sel;
  logic [31:0] out_shiftee;
  logic [31:0] out_shifter;
  logic [31:0] out_rn;
  logic [31:0] out_instr;

  logic [31:0] regs [16];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  bsel;
    logic [31:0] shiftee;
    logic [31:0] shifter;
    logic [31:0] rn;
    logic [31:0] instr;
  } bundle_t;

  always #5 clk = ~clk;

  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];

  shifter_operand_fetch #(.PC_OFS_IMM(32'd8), .PC_OFS_REG(32'd12)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_addr_a(rf_addr_a), .rf_data_a(rf_data_a),
    .rf_addr_b(rf_addr_b), .rf_data_b(rf_data_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_barrel_sel(out_barrel_sel), .out_shiftee(out_shiftee),
    .out_shifter(out_shifter), .out_rn(out_rn), .out_instr(out_instr)
  );

  // Architectural view of a register read: R15 reads as PC plus pipeline offset.
  function automatic logic [31:0] rd_reg(input logic [3:0] r, input logic [31:0] pc,
                                         input bit regform);
    if (r == 4'd15) return pc + (regform ? 32'd12 : 32'd8);
    return regs[r];
  endfunction

  function automatic bundle_t model(input logic [31:0] instr, input logic [31:0] pc);
    bundle_t b;
    bit regform;
    regform = !instr[25] && instr[4];
    b.instr = instr;
    b.rn    = rd_reg(instr[19:16], pc, regform);
    if (instr[25]) begin
      b.bsel    = 4'd8;
      b.shiftee = {24'd0, instr[7:0]};
      b.shifter = {28'd0, instr[11:8]};
    end else begin
      b.bsel    = {1'b0, instr[6:5], regform};
      b.shiftee = rd_reg(instr[3:0], pc, regform);
      b.shifter = regform ? rd_reg(instr[11:8], pc, regform) : {27'd0, instr[11:7]};
    end
    return b;
  endfunction

  function automatic bundle_t observed();
    return {out_barrel_sel, out_shiftee, out_shifter, out_rn, out_instr};
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    in_instr = 32'h000A_0003;
    #10;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (observed() !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", observed()); end
    n_checks++;
    if (rf_addr_a !== 4'hA || rf_addr_b !== 4'h3) begin
      n_fail++; $display("FAIL reset_addr: got a=%h b=%h expected a=a b=3", rf_addr_a, rf_addr_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_immediate();
    bundle_t e;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hE3A010FF; in_pc = 32'h100; out_ready = 1'b1;
    e = model(in_instr, in_pc);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL imm_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_barrel_sel !== 4'd8 || out_shiftee !== 32'hFF || out_shifter !== 32'd0) begin
      n_fail++; $display("FAIL imm_bundle: got v=%b sel=%h se=%h sh=%h expected v=1 sel=8 se=ff sh=0",
                         out_valid, out_barrel_sel, out_shiftee, out_shifter);
    end
    n_checks++;
    if (observed() !== e) begin n_fail++; $display("FAIL imm_model: got %h expected %h", observed(), e); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL imm_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_imm_shift();
    regs[2] = 32'h8000_0001;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hE1A01FC2; in_pc = 32'h104;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_barrel_sel !== 4'd4 || out_shiftee !== 32'h8000_0001 || out_shifter !== 32'd31) begin
      n_fail++; $display("FAIL immshift_bundle: got v=%b sel=%h se=%h sh=%h expected v=1 sel=4 se=80000001 sh=1f",
                         out_valid, out_barrel_sel, out_shiftee, out_shifter);
    end
  endtask

  task automatic test_reg_shift();
    bundle_t e2;
    regs[3] = 32'h12; regs[4] = 32'h104;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hE0831413; in_pc = 32'h108;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || rf_addr_a !== 4'd3) begin
      n_fail++; $display("FAIL regshift_accept: got rdy=%b a=%h expected rdy=1 a=3", in_ready, rf_addr_a);
    end
    @(negedge clk);
    in_instr = 32'hE3A025AA; in_pc = 32'h10C;
    e2 = model(in_instr, in_pc);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || rf_addr_a !== 4'd4) begin
      n_fail++; $display("FAIL regshift_rsread: got rdy=%b v=%b a=%h expected rdy=0 v=0 a=4",
                         in_ready, out_valid, rf_addr_a);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_barrel_sel !== 4'd1 || out_shifter !== 32'h104 ||
        out_rn !== 32'h12 || out_shiftee !== 32'h12) begin
      n_fail++; $display("FAIL regshift_bundle: got v=%b sel=%h sh=%h rn=%h se=%h expected v=1 sel=1 sh=104 rn=12 se=12",
                         out_valid, out_barrel_sel, out_shifter, out_rn, out_shiftee);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || observed() !== e2) begin
      n_fail++; $display("FAIL regshift_next: got v=%b %h expected v=1 %h", out_valid, observed(), e2);
    end
    @(negedge clk);
  endtask

  task automatic test_r15();
    regs[15] = 32'hDEAD_BEEF;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hE08F100F; in_pc = 32'h200;
    @(negedge clk);
    in_instr = 32'hE08F1F1F;
    n_checks++;
    if (out_valid !== 1'b1 || out_rn !== 32'h208 || out_shiftee !== 32'h208) begin
      n_fail++; $display("FAIL r15_imm: got v=%b rn=%h se=%h expected v=1 rn=208 se=208", out_valid, out_rn, out_shiftee);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_rn !== 32'h20C || out_shiftee !== 32'h20C || out_shifter !== 32'h20C) begin
      n_fail++; $display("FAIL r15_reg: got v=%b rn=%h se=%h sh=%h expected v=1 rn=20c se=20c sh=20c",
                         out_valid, out_rn, out_shiftee, out_shifter);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [3];
    bundle_t e [3];
    ins[0] = 32'hE3A01011; ins[1] = 32'hE3A02322; ins[2] = 32'hE3A03C33;
    for (int k = 0; k < 3; k++) e[k] = model(ins[k], 32'h300 + 32'(4 * k));
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = ins[0]; in_pc = 32'h300;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_instr = ins[1]; in_pc = 32'h304;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || observed() !== e[0] || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold: got v=%b rdy=%b %h expected v=1 rdy=0 %h",
                           out_valid, in_ready, observed(), e[0]);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || observed() !== e[0] || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got v=%b rdy=%b %h expected v=1 rdy=1 %h",
                         out_valid, in_ready, observed(), e[0]);
    end
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || observed() !== e[k]) begin
        n_fail++; $display("FAIL b2b_bundle%0d: got v=%b %h expected v=1 %h", k, out_valid, observed(), e[k]);
      end
      if (k == 1) begin in_instr = ins[2]; in_pc = 32'h308; end
      else in_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    bundle_t e;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hE0831413; in_pc = 32'h400; out_ready = 1'b1;
    @(negedge clk);
    in_instr = 32'hE3A01077; in_pc = 32'h404; flush = 1'b1;
    e = model(in_instr, in_pc);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_recover: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || observed() !== e) begin
      n_fail++; $display("FAIL flush_next: got v=%b %h expected v=1 %h", out_valid, observed(), e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hE3A01055; in_pc = 32'h500;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_before_reset: got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || observed() !== '0) begin
      n_fail++; $display("FAIL async_reset: got v=%b %h expected v=0 0", out_valid, observed());
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
  endtask

  task automatic test_random();
    bundle_t q[$];
    bit      rs_pending = 1'b0;
    bit      exp_valid, exp_ready;
    for (int k = 0; k < 15; k++) regs[k] = $urandom;
    for (int i = 0; i < 406; i++) begin
      @(negedge clk);
      exp_valid = (q.size() > 0) && !rs_pending;
      n_checks++;
      if (out_valid !== exp_valid) begin
        n_fail++; $display("FAIL rand_valid@%0d: got %b expected %b", i, out_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (observed() !== q[0]) begin
          n_fail++; $display("FAIL rand_bundle@%0d: got %h expected %h", i, observed(), q[0]);
        end
      end
      in_valid  = (i < 400) && ($urandom_range(0, 3) != 0);
      in_instr  = $urandom;
      in_pc     = $urandom & 32'hFFFF_FFFC;
      out_ready = (i >= 400) || ($urandom_range(0, 3) != 0);
      flush     = (i < 400) && ($urandom_range(0, 19) == 0);
      #1;
      exp_ready = !flush && !rs_pending && (!exp_valid || out_ready);
      n_checks++;
      if (in_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready@%0d: got %b expected %b", i, in_ready, exp_ready);
      end
      if (flush) begin
        q.delete();
        rs_pending = 1'b0;
      end else if (rs_pending) begin
        rs_pending = 1'b0;
      end else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready) begin
          q.push_back(model(in_instr, in_pc));
          rs_pending = !in_instr[25] && in_instr[4];
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) regs[k] = $urandom;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    test_reset();
    test_immediate();
    test_imm_shift();
    test_reg_shift();
    test_r15();
    test_back_to_back();
    test_flush();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
